// File: rtl/tx_fifo_wr_arbiter.sv
// tx_fifo_wr_arbiter
//  Shares the TX async-FIFO write port between register-file read bytes and
//  ALU results. Round-robin between the two sources, a single holding register,
//  and FIFO_FULL back-pressure. Each ALU result goes out as two FIFO bytes.
// Ports
//  CLK, RST     write-domain clock, asynchronous active-low reset
//  RF_VALID/RF_DATA/RF_READY     register-file byte handshake
//  ALU_VALID/ALU_DATA/ALU_READY  ALU result handshake
//  FIFO_FULL    FIFO write-side full flag
//  WR_INC       FIFO write strobe (combinational: !FIFO_FULL while sending)
//  WR_DATA      FIFO write byte (0 in IDLE)
//  BUSY         high in any state other than IDLE
module tx_fifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ALU_WIDTH     = 16,
   parameter bit          ALU_MSB_FIRST = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RF_VALID,
   input  logic [DATA_WIDTH-1:0] RF_DATA,
   output logic                  RF_READY,
   input  logic                  ALU_VALID,
   input  logic [ALU_WIDTH-1:0]  ALU_DATA,
   output logic                  ALU_READY,
   input  logic                  FIFO_FULL,
   output logic                  WR_INC,
   output logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND_RF = 2'd1,
      ST_SEND_B0 = 2'd2,
      ST_SEND_B1 = 2'd3
   } state_e;

   typedef enum logic {
      SRC_RF  = 1'b0,
      SRC_ALU = 1'b1
   } src_e;

   state_e                 state;
   state_e                 state_nxt;
   src_e                   last_grant;
   logic [ALU_WIDTH-1:0]   hold_reg;
   logic                   grant_rf;
   logic                   grant_alu;
   logic [DATA_WIDTH-1:0]  byte_lo;
   logic [DATA_WIDTH-1:0]  byte_hi;
   logic [DATA_WIDTH-1:0]  byte_first;
   logic [DATA_WIDTH-1:0]  byte_second;

   assign byte_lo     = hold_reg[DATA_WIDTH-1:0];
   assign byte_hi     = hold_reg[ALU_WIDTH-1 -: DATA_WIDTH];
   assign byte_first  = ALU_MSB_FIRST ? byte_hi : byte_lo;
   assign byte_second = ALU_MSB_FIRST ? byte_lo : byte_hi;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, grant and FIFO write outputs
   always_comb begin
      state_nxt = state;
      grant_rf  = 1'b0;
      grant_alu = 1'b0;
      WR_INC    = 1'b0;
      WR_DATA   = '0;
      case (state)
         ST_IDLE: begin
            // RST gating keeps READY low while reset is held
            if (RST) begin
               if (RF_VALID && (!ALU_VALID || (last_grant == SRC_ALU))) begin
                  grant_rf = 1'b1;
               end else if (ALU_VALID) begin
                  grant_alu = 1'b1;
               end
            end
            if (grant_rf) begin
               state_nxt = ST_SEND_RF;
            end else if (grant_alu) begin
               state_nxt = ST_SEND_B0;
            end
         end
         ST_SEND_RF: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = byte_lo;
            if (!FIFO_FULL) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SEND_B0: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = byte_first;
            if (!FIFO_FULL) begin
               state_nxt = ST_SEND_B1;
            end
         end
         ST_SEND_B1: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = byte_second;
            if (!FIFO_FULL) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Capture granted data and remember who was served for the next tie
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hold_reg   <= '0;
         last_grant <= SRC_ALU;
      end else if (grant_rf) begin
         hold_reg   <= ALU_WIDTH'(RF_DATA);
         last_grant <= SRC_RF;
      end else if (grant_alu) begin
         hold_reg   <= ALU_DATA;
         last_grant <= SRC_ALU;
      end
   end

   assign RF_READY  = grant_rf;
   assign ALU_READY = grant_alu;
   assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_fifo_wr_arbiter.sv
// tb_tx_fifo_wr_arbiter
//  Directed bench for tx_fifo_wr_arbiter. Two instances share the stimulus: dut0
//  sends ALU low byte first, dut1 high byte first. Inputs change 1 ns after the
//  rising edge; outputs are checked on the falling edge.
module tb_tx_fifo_wr_arbiter;

   logic        CLK;
   logic        RST;
   logic        RF_VALID;
   logic [7:0]  RF_DATA;
   logic        ALU_VALID;
   logic [15:0] ALU_DATA;
   logic        FIFO_FULL;

   logic        rf_ready0,  alu_ready0, wr_inc0, busy0;
   logic [7:0]  wr_data0;
   logic        rf_ready1,  alu_ready1, wr_inc1, busy1;
   logic [7:0]  wr_data1;

   int n_checks = 0;
   int n_errors = 0;

   tx_fifo_wr_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ALU_MSB_FIRST(1'b0)) dut0 (
      .CLK(CLK), .RST(RST),
      .RF_VALID(RF_VALID), .RF_DATA(RF_DATA), .RF_READY(rf_ready0),
      .ALU_VALID(ALU_VALID), .ALU_DATA(ALU_DATA), .ALU_READY(alu_ready0),
      .FIFO_FULL(FIFO_FULL), .WR_INC(wr_inc0), .WR_DATA(wr_data0), .BUSY(busy0)
   );

   tx_fifo_wr_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ALU_MSB_FIRST(1'b1)) dut1 (
      .CLK(CLK), .RST(RST),
      .RF_VALID(RF_VALID), .RF_DATA(RF_DATA), .RF_READY(rf_ready1),
      .ALU_VALID(ALU_VALID), .ALU_DATA(ALU_DATA), .ALU_READY(alu_ready1),
      .FIFO_FULL(FIFO_FULL), .WR_INC(wr_inc1), .WR_DATA(wr_data1), .BUSY(busy1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, check dut0 outputs mid-cycle
   task automatic cyc(input string tag,
                      input logic rv, input logic [7:0] rd,
                      input logic av, input logic [15:0] ad, input logic full,
                      input logic e_rr, input logic e_ar, input logic e_wi,
                      input logic [7:0] e_wd, input logic e_busy);
      @(posedge CLK);
      #1;
      RF_VALID  = rv;
      RF_DATA   = rd;
      ALU_VALID = av;
      ALU_DATA  = ad;
      FIFO_FULL = full;
      @(negedge CLK);
      check_val({tag, ".rf_ready"},  16'(rf_ready0),  16'(e_rr));
      check_val({tag, ".alu_ready"}, 16'(alu_ready0), 16'(e_ar));
      check_val({tag, ".wr_inc"},    16'(wr_inc0),    16'(e_wi));
      check_val({tag, ".wr_data"},   16'(wr_data0),   16'(e_wd));
      check_val({tag, ".busy"},      16'(busy0),      16'(e_busy));
   endtask

   logic [7:0] rf_bytes [5];

   initial begin
      rf_bytes[0] = 8'hC1; rf_bytes[1] = 8'h72; rf_bytes[2] = 8'h0F;
      rf_bytes[3] = 8'hE4; rf_bytes[4] = 8'h39;

      // Reset: READY must stay low even with a request pending
      RST = 1'b0; RF_VALID = 1'b1; RF_DATA = 8'h99;
      ALU_VALID = 1'b0; ALU_DATA = 16'h0; FIFO_FULL = 1'b0;
      #2;
      check_val("rst.rf_ready", 16'(rf_ready0), 16'h0);
      check_val("rst.wr_inc",   16'(wr_inc0),   16'h0);
      check_val("rst.wr_data",  16'(wr_data0),  16'h0);
      check_val("rst.busy",     16'(busy0),     16'h0);
      @(posedge CLK);
      #1;
      RST = 1'b1; RF_VALID = 1'b0; RF_DATA = 8'h00;

      // 1: single RF byte
      cyc("t1.c0", 1, 8'h5A, 0, 16'h0, 0,  1, 0, 0, 8'h00, 0);
      cyc("t1.c1", 0, 8'h00, 0, 16'h0, 0,  0, 0, 1, 8'h5A, 1);
      cyc("t1.c2", 0, 8'h00, 0, 16'h0, 0,  0, 0, 0, 8'h00, 0);

      // 2: ALU result, both byte orders
      cyc("t2.c0", 0, 8'h00, 1, 16'hBEEF, 0,  0, 1, 0, 8'h00, 0);
      check_val("t2.msb.alu_ready", 16'(alu_ready1), 16'h1);
      cyc("t2.c1", 0, 8'h00, 0, 16'h0, 0,  0, 0, 1, 8'hEF, 1);
      check_val("t2.msb.b0_inc",  16'(wr_inc1),  16'h1);
      check_val("t2.msb.b0_data", 16'(wr_data1), 16'h00BE);
      cyc("t2.c2", 0, 8'h00, 0, 16'h0, 0,  0, 0, 1, 8'hBE, 1);
      check_val("t2.msb.b1_inc",  16'(wr_inc1),  16'h1);
      check_val("t2.msb.b1_data", 16'(wr_data1), 16'h00EF);
      cyc("t2.c3", 0, 8'h00, 0, 16'h0, 0,  0, 0, 0, 8'h00, 0);
      check_val("t2.msb.idle_busy", 16'(busy1), 16'h0);

      // 3: ties and round-robin (last grant is ALU after t2)
      cyc("t3.c0",  1, 8'h11, 1, 16'h2233, 0,  1, 0, 0, 8'h00, 0);
      cyc("t3.c1",  0, 8'h00, 1, 16'h2233, 0,  0, 0, 1, 8'h11, 1);
      cyc("t3.c2",  0, 8'h00, 1, 16'h2233, 0,  0, 1, 0, 8'h00, 0);
      cyc("t3.c3",  0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h33, 1);
      cyc("t3.c4",  0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h22, 1);
      cyc("t3.c5",  1, 8'h44, 1, 16'h5566, 0,  1, 0, 0, 8'h00, 0);
      cyc("t3.c6",  1, 8'h77, 1, 16'h5566, 0,  0, 0, 1, 8'h44, 1);
      cyc("t3.c7",  1, 8'h77, 1, 16'h5566, 0,  0, 1, 0, 8'h00, 0);
      cyc("t3.c8",  1, 8'h77, 0, 16'h0,    0,  0, 0, 1, 8'h66, 1);
      cyc("t3.c9",  1, 8'h77, 0, 16'h0,    0,  0, 0, 1, 8'h55, 1);
      cyc("t3.c10", 1, 8'h77, 0, 16'h0,    0,  1, 0, 0, 8'h00, 0);
      cyc("t3.c11", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h77, 1);
      cyc("t3.c12", 0, 8'h00, 0, 16'h0,    0,  0, 0, 0, 8'h00, 0);

      // 4: FIFO full between the two ALU bytes
      cyc("t4.c0", 0, 8'h00, 1, 16'hA55A, 0,  0, 1, 0, 8'h00, 0);
      cyc("t4.c1", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h5A, 1);
      for (int i = 0; i < 4; i++) begin
         cyc($sformatf("t4.stall%0d", i), 0, 8'h00, 0, 16'h0, 1,  0, 0, 0, 8'hA5, 1);
      end
      cyc("t4.c6", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'hA5, 1);
      cyc("t4.c7", 0, 8'h00, 0, 16'h0,    0,  0, 0, 0, 8'h00, 0);

      // 5: reset asserted while in SEND_B1
      cyc("t5.c0", 0, 8'h00, 1, 16'h1234, 0,  0, 1, 0, 8'h00, 0);
      cyc("t5.c1", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h34, 1);
      cyc("t5.c2", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h12, 1);
      #2;
      RST = 1'b0;
      #1;
      check_val("t5.rst.wr_inc",  16'(wr_inc0),  16'h0);
      check_val("t5.rst.busy",    16'(busy0),    16'h0);
      check_val("t5.rst.wr_data", 16'(wr_data0), 16'h0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      cyc("t5.c3", 0, 8'h00, 1, 16'h0102, 0,  0, 1, 0, 8'h00, 0);
      cyc("t5.c4", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h02, 1);
      cyc("t5.c5", 0, 8'h00, 0, 16'h0,    0,  0, 0, 1, 8'h01, 1);
      cyc("t5.c6", 0, 8'h00, 0, 16'h0,    0,  0, 0, 0, 8'h00, 0);

      // 6: RF_VALID held across five bytes, one write every two cycles
      for (int i = 0; i < 5; i++) begin
         cyc($sformatf("t6.grant%0d", i), 1, rf_bytes[i], 0, 16'h0, 0,  1, 0, 0, 8'h00, 0);
         if (i < 4) begin
            cyc($sformatf("t6.write%0d", i), 1, rf_bytes[i+1], 0, 16'h0, 0,
                0, 0, 1, rf_bytes[i], 1);
         end else begin
            cyc($sformatf("t6.write%0d", i), 0, 8'h00, 0, 16'h0, 0,
                0, 0, 1, rf_bytes[i], 1);
         end
      end
      cyc("t6.idle", 0, 8'h00, 0, 16'h0, 0,  0, 0, 0, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
